// File: rtl/bypass_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight destination registers,
// selects the forwarding stage for each decode source and stalls on unready loads.
module bypass_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int RW       = 5,
    localparam int FW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          id_wr,
    input  logic [RW-1:0] id_rd,
    input  logic          id_is_load,
    input  logic          flush,
    output logic          stall,
    output logic [FW-1:0] fwd_rs,
    output logic [FW-1:0] fwd_rt,
    output logic [7:0]    stall_cnt
);

    logic [DEPTH:1]         vld_q, vld_d;
    logic [DEPTH:1]         ld_q, ld_d;
    logic [DEPTH:1][RW-1:0] rd_q, rd_d;
    logic [7:0]             stall_cnt_q, stall_cnt_d;

    logic          rs_hit, rs_rdy, rt_hit, rt_rdy;
    logic [FW-1:0] rs_k, rt_k;

    // Scan oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        rs_hit = 1'b0;
        rs_rdy = 1'b0;
        rs_k   = '0;
        rt_hit = 1'b0;
        rt_rdy = 1'b0;
        rt_k   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_rs_used && id_rs != '0 && vld_q[k] && rd_q[k] == id_rs) begin
                rs_hit = 1'b1;
                rs_rdy = !ld_q[k] || (k >= LOAD_LAT);
                rs_k   = FW'(k);
            end
            if (id_rt_used && id_rt != '0 && vld_q[k] && rd_q[k] == id_rt) begin
                rt_hit = 1'b1;
                rt_rdy = !ld_q[k] || (k >= LOAD_LAT);
                rt_k   = FW'(k);
            end
        end
    end

    always_comb begin
        stall  = !rst && id_valid && ((rs_hit && !rs_rdy) || (rt_hit && !rt_rdy));
        fwd_rs = (!rst && id_valid && !stall && rs_hit) ? rs_k : '0;
        fwd_rt = (!rst && id_valid && !stall && rt_hit) ? rt_k : '0;
    end

    always_comb begin
        vld_d       = '0;
        rd_d        = rd_q;
        ld_d        = ld_q;
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 8'hff)
            stall_cnt_d = stall_cnt_q + 8'd1;
        // A flush leaves every valid bit at zero; payloads are don't-care.
        if (!flush) begin
            for (int k = DEPTH; k >= 2; k--) begin
                vld_d[k] = vld_q[k-1];
                rd_d[k]  = rd_q[k-1];
                ld_d[k]  = ld_q[k-1];
            end
            vld_d[1] = id_valid && !stall && id_wr && id_rd != '0;
            rd_d[1]  = id_rd;
            ld_d[1]  = id_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            ld_q        <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Bench for bypass_scoreboard: default-parameter instance driven from a vector
// table plus corner sequences, and a DEPTH=5/LOAD_LAT=3 instance.
module tb_bypass_scoreboard;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic       rsu, rtu, wr;
        logic [4:0] rd;
        logic       ld, fl;
        logic       e_stall;
        logic [1:0] e_rs, e_rt;
    } vec_t;

    typedef struct {
        logic       stall;
        logic [1:0] rs, rt;
        string      nm;
    } exp_t;

    logic       clk;
    logic       rst, id_valid, id_rs_used, id_rt_used, id_wr, id_is_load, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall;
    logic [1:0] fwd_rs, fwd_rt;
    logic [7:0] stall_cnt;

    logic       rst2, id_valid2, id_rs_used2, id_rt_used2, id_wr2, id_is_load2, flush2;
    logic [4:0] id_rs2, id_rt2, id_rd2;
    logic       stall2;
    logic [2:0] fwd_rs2, fwd_rt2;
    logic [7:0] stall_cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];
    vec_t vecs[15];

    bypass_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_rs(fwd_rs),
        .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
    );

    bypass_scoreboard #(.DEPTH(5), .LOAD_LAT(3), .RW(5)) dut2 (
        .clk(clk), .rst(rst2), .id_valid(id_valid2), .id_rs(id_rs2), .id_rt(id_rt2),
        .id_rs_used(id_rs_used2), .id_rt_used(id_rt_used2), .id_wr(id_wr2), .id_rd(id_rd2),
        .id_is_load(id_is_load2), .flush(flush2), .stall(stall2), .fwd_rs(fwd_rs2),
        .fwd_rt(fwd_rt2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit v, input int rs, input int rt, input bit rsu,
                                input bit rtu, input bit wr, input int rd, input bit ld,
                                input bit fl, input bit es, input int ers, input int ert);
        vec_t m;
        m.valid = v;  m.rs = 5'(rs);  m.rt = 5'(rt);  m.rsu = rsu;  m.rtu = rtu;
        m.wr = wr;  m.rd = 5'(rd);  m.ld = ld;  m.fl = fl;
        m.e_stall = es;  m.e_rs = 2'(ers);  m.e_rt = 2'(ert);
        return m;
    endfunction

    // Drive one decode cycle; outputs are combinational, checked mid-cycle.
    task automatic drive(input vec_t v, input string nm);
        exp_t e;
        id_valid = v.valid;  id_rs = v.rs;  id_rt = v.rt;  id_rs_used = v.rsu;
        id_rt_used = v.rtu;  id_wr = v.wr;  id_rd = v.rd;  id_is_load = v.ld;  flush = v.fl;
        q.push_back('{stall: v.e_stall, rs: v.e_rs, rt: v.e_rt, nm: nm});
        @(negedge clk);
        e = q.pop_front();
        chk({e.nm, ".stall"}, int'(stall), int'(e.stall));
        chk({e.nm, ".fwd_rs"}, int'(fwd_rs), int'(e.rs));
        chk({e.nm, ".fwd_rt"}, int'(fwd_rt), int'(e.rt));
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input bit v, input int rs, input bit rsu, input bit wr, input int rd,
                         input bit ld, input bit es, input int ef, input string nm);
        id_valid2 = v;  id_rs2 = 5'(rs);  id_rs_used2 = rsu;  id_wr2 = wr;
        id_rd2 = 5'(rd);  id_is_load2 = ld;
        @(negedge clk);
        chk({nm, ".stall"}, int'(stall2), int'(es));
        chk({nm, ".fwd_rs"}, int'(fwd_rs2), ef);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;  rst2 = 1'b1;
        id_valid = 1'b1;  id_rs = 5'd3;  id_rt = 5'd3;  id_rs_used = 1'b1;  id_rt_used = 1'b1;
        id_wr = 1'b1;  id_rd = 5'd3;  id_is_load = 1'b1;  flush = 1'b0;
        id_valid2 = 1'b0;  id_rs2 = '0;  id_rt2 = '0;  id_rs_used2 = 1'b0;  id_rt_used2 = 1'b0;
        id_wr2 = 1'b0;  id_rd2 = '0;  id_is_load2 = 1'b0;  flush2 = 1'b0;

        // {valid, rs, rt, rs_used, rt_used, wr, rd, is_load, flush, stall, fwd_rs, fwd_rt}
        vecs[0]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0);  // ADD r3
        vecs[1]  = mk(1, 3, 0, 1, 0, 1, 8, 0, 0, 0, 1, 0);  // SUB reads r3 from EX
        vecs[2]  = mk(1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 2, 2);  // r3 now in stage 2
        vecs[3]  = mk(0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 9, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0);  // LW r5
        vecs[5]  = mk(1, 1, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0);  // SW rt=r5: load-use stall
        vecs[6]  = mk(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 2);
        vecs[7]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);  // ADD r7
        vecs[8]  = mk(1, 7, 0, 1, 0, 1, 7, 0, 0, 0, 1, 0);  // ADD r7
        vecs[9]  = mk(1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 1, 1);  // youngest wins
        vecs[10] = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);  // LW r0: never tracked
        vecs[11] = mk(1, 0, 0, 1, 1, 1, 4, 1, 0, 0, 0, 0);  // reads r0, LW r4
        vecs[12] = mk(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);  // rs=r4 but unused
        vecs[13] = mk(1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 2);
        vecs[14] = mk(0, 4, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0);  // invalid decode

        @(negedge clk);
        chk("reset.stall", int'(stall), 0);
        chk("reset.fwd_rs", int'(fwd_rs), 0);
        chk("reset.stall_cnt", int'(stall_cnt), 0);
        chk("reset2.stall_cnt", int'(stall_cnt2), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;  rst2 = 1'b0;

        for (int i = 0; i < 15; i++) drive(vecs[i], $sformatf("vec%0d", i));
        chk("table.stall_cnt", int'(stall_cnt), 1);

        // Flush while a load-dependent is stalled.
        drive(mk(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0), "lw_r6");
        drive(mk(1, 6, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0), "flush_stalled");
        drive(mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "after_flush");
        chk("flush.stall_cnt", int'(stall_cnt), 2);

        // Each load followed by a dependent gives one stall cycle.
        for (int i = 0; i < 300; i++) begin
            drive(mk(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0), "sat_lw");
            drive(mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "sat_use");
        end
        chk("sat.stall_cnt", int'(stall_cnt), 255);

        // Asynchronous reset while stalled, then resume empty.
        drive(mk(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0), "pre_rst_lw");
        id_valid = 1'b1;  id_rs = 5'd6;  id_rs_used = 1'b1;  id_rt_used = 1'b0;
        id_wr = 1'b0;  id_is_load = 1'b0;
        @(negedge clk);
        chk("pre_rst.stall", int'(stall), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.stall", int'(stall), 0);
        chk("async_rst.fwd_rs", int'(fwd_rs), 0);
        chk("async_rst.stall_cnt", int'(stall_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst.stall", int'(stall), 0);
        chk("post_rst.fwd_rs", int'(fwd_rs), 0);
        @(posedge clk);
        #1;

        // DEPTH=5, LOAD_LAT=3 instance.
        step2(1, 0, 0, 1, 2, 1, 0, 0, "d5_lw_r2");
        step2(1, 2, 1, 0, 0, 0, 1, 0, "d5_use_k1");
        step2(1, 2, 1, 0, 0, 0, 1, 0, "d5_use_k2");
        step2(1, 2, 1, 0, 0, 0, 0, 3, "d5_use_k3");
        chk("d5.stall_cnt", int'(stall_cnt2), 2);
        step2(1, 0, 0, 1, 2, 1, 0, 0, "d5_lw_r2b");
        id_rs2 = 5'd2;  id_rs_used2 = 1'b1;  id_wr2 = 1'b0;  id_is_load2 = 1'b0;
        @(negedge clk);
        chk("d5_pre_rst.stall", int'(stall2), 1);
        #2 rst2 = 1'b1;
        #1;
        chk("d5_async_rst.stall", int'(stall2), 0);
        chk("d5_async_rst.fwd_rs", int'(fwd_rs2), 0);
        chk("d5_async_rst.stall_cnt", int'(stall_cnt2), 0);
        @(posedge clk);
        #1 rst2 = 1'b0;
        @(negedge clk);
        chk("d5_post_rst.stall", int'(stall2), 0);

        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
